// File: rtl/radix4_seq_mult_pkg.sv
// Shared types and helpers for the radix-4 sequential multiplier.
package radix4_seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // One radix-4 digit retires per CALC cycle.
  function automatic int digits_f(input int width);
    return width / 2;
  endfunction

endpackage

// File: rtl/radix4_seq_mult_digit.sv
// Radix-4 partial product a*d for d in {0,1,2,3}; purely combinational, no handshake.
module mult_digit #(
  parameter int WIDTH = 8
) (
  input  logic [2*WIDTH-1:0] a,
  input  logic [1:0]         d,
  output logic [2*WIDTH-1:0] pp
);

  always_comb begin
    pp = '0;
    unique case (d)
      2'd0:    pp = '0;
      2'd1:    pp = a;
      2'd2:    pp = a << 1;
      2'd3:    pp = a + (a << 1);
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/radix4_seq_mult.sv
// Iterative WIDTH x WIDTH radix-4 multiplier: product valid WIDTH/2 edges after accept, held under out_ready=0.
// Optional two's complement mode behind RADIX4_SEQ_MULT_SIGNED_EN (adds signed_i).
module radix4_seq_mult
  import radix4_seq_mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH/2) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
`ifdef RADIX4_SEQ_MULT_SIGNED_EN
  input  logic               signed_i,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int PW     = 2 * WIDTH;
  localparam int DIGITS = digits_f(WIDTH);

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("radix4_seq_mult: WIDTH must be even and >= 4");
  end

  state_e            state_q, state_d;
  logic [PW-1:0]     a_reg, acc, pp, acc_next, prod_next, product_q;
  logic [WIDTH-1:0]  b_reg, a_mag, b_mag;
  logic [CNT_W-1:0]  cnt;
  logic              accept, last;

  assign accept   = in_valid && in_ready;
  assign last     = (state_q == CALC) && (cnt == CNT_W'(DIGITS - 1));
  assign acc_next = acc + pp;

  mult_digit #(.WIDTH(WIDTH)) u_digit (
    .a  (a_reg),
    .d  (b_reg[1:0]),
    .pp (pp)
  );

`ifdef RADIX4_SEQ_MULT_SIGNED_EN
  logic neg_a, neg_b, sign_q;
  assign neg_a     = signed_i && a_i[WIDTH-1];
  assign neg_b     = signed_i && b_i[WIDTH-1];
  assign a_mag     = neg_a ? (~a_i + 1'b1) : a_i;
  assign b_mag     = neg_b ? (~b_i + 1'b1) : b_i;
  // Negate once at the end; the accumulator only ever sees magnitudes.
  assign prod_next = sign_q ? (~acc_next + 1'b1) : acc_next;
`else
  assign a_mag     = a_i;
  assign b_mag     = b_i;
  assign prod_next = acc_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = CALC;
      end
      CALC: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_d = in_valid ? CALC : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      cnt       <= '0;
      product_q <= '0;
`ifdef RADIX4_SEQ_MULT_SIGNED_EN
      sign_q    <= 1'b0;
`endif
    end else if (accept) begin
      a_reg  <= {{WIDTH{1'b0}}, a_mag};
      b_reg  <= b_mag;
      acc    <= '0;
      cnt    <= '0;
`ifdef RADIX4_SEQ_MULT_SIGNED_EN
      sign_q <= neg_a ^ neg_b;
`endif
    end else if (state_q == CALC) begin
      acc   <= acc_next;
      a_reg <= a_reg << 2;
      b_reg <= b_reg >> 2;
      cnt   <= cnt + CNT_W'(1);
      // Output register only moves on CALC->DONE, so it is frozen while DONE waits.
      if (last) product_q <= prod_next;
    end
  end

  assign product_o = product_q;

endmodule

// File: tb/tb_radix4_seq_mult.sv
// Scoreboard bench: WIDTH=8 directed cases and a WIDTH=16 sweep; signed cases when RADIX4_SEQ_MULT_SIGNED_EN is defined.
module tb_radix4_seq_mult;

  logic clk, rst_n;
  int   cyc = 0;
  int   n_chk = 0, n_fail = 0;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  a8, b8;
  logic [15:0] product8;
  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0] a16, b16;
  logic [31:0] product16;
`ifdef RADIX4_SEQ_MULT_SIGNED_EN
  logic        sgn8;
  logic        sgn16;
`endif

  logic [15:0] q8[$];
  logic [31:0] q16[$];
  int          acc_cyc8 = 0, acc_cyc16 = 0;
  logic        ov8_prev = 1'b0, ov16_prev = 1'b0;

  radix4_seq_mult #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a_i       (a8),
    .b_i       (b8),
`ifdef RADIX4_SEQ_MULT_SIGNED_EN
    .signed_i  (sgn8),
`endif
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .product_o (product8)
  );

  radix4_seq_mult #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .a_i       (a16),
    .b_i       (b16),
`ifdef RADIX4_SEQ_MULT_SIGNED_EN
    .signed_i  (sgn16),
`endif
    .out_valid (out_valid16),
    .out_ready (out_ready16),
    .product_o (product16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitors: compare on handshake, check latency on each rising out_valid.
  always @(negedge clk) begin
    if (out_valid8 && !ov8_prev) check("lat8", 64'(cyc - acc_cyc8), 64'(4));
    ov8_prev = out_valid8;
    if (out_valid8 && out_ready8) begin
      if (q8.size() == 0) check("unexpected8", 64'(product8), 64'hDEAD_BEEF_0000_0000);
      else                check("prod8", 64'(product8), 64'(q8.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (out_valid16 && !ov16_prev) check("lat16", 64'(cyc - acc_cyc16), 64'(8));
    ov16_prev = out_valid16;
    if (out_valid16 && out_ready16) begin
      if (q16.size() == 0) check("unexpected16", 64'(product16), 64'hDEAD_BEEF_0000_0000);
      else                 check("prod16", 64'(product16), 64'(q16.pop_front()));
    end
  end

  // Drives a pair and leaves in_valid high; returns 1ns after the accepting edge.
  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp, input bit push);
    int   k;
    logic ok;
    a8 = a; b8 = b; in_valid8 = 1'b1; k = 0;
    do begin
      #1 ok = in_ready8;
      @(posedge clk);
      k++;
    end while (!ok && k < 200);
    #1;
    check("accept8", 64'(ok), 64'(1));
    if (ok) begin
      acc_cyc8 = cyc;
      if (push) q8.push_back(exp);
    end
  endtask

  task automatic send16(input logic [15:0] a, input logic [15:0] b);
    int   k;
    logic ok;
    a16 = a; b16 = b; in_valid16 = 1'b1; k = 0;
    do begin
      #1 ok = in_ready16;
      @(posedge clk);
      k++;
    end while (!ok && k < 200);
    #1;
    check("accept16", 64'(ok), 64'(1));
    if (ok) begin
      acc_cyc16 = cyc;
      q16.push_back({16'h0, a} * {16'h0, b});
    end
  endtask

  task automatic drain(input int which);
    int k;
    k = 0;
    while (((which == 8) ? q8.size() : q16.size()) != 0 && k < 1000) begin
      @(posedge clk);
      k++;
    end
    #1;
    check((which == 8) ? "drain8" : "drain16",
          64'((which == 8) ? q8.size() : q16.size()), 64'(0));
  endtask

  int t1, t2, t3, k;

  initial begin
    rst_n = 1'b0;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; out_ready8 = 1'b1;
    in_valid16 = 1'b0; a16 = '0; b16 = '0; out_ready16 = 1'b1;
`ifdef RADIX4_SEQ_MULT_SIGNED_EN
    sgn8 = 1'b0; sgn16 = 1'b0;
`endif
    #2;
    check("rst_in_ready", 64'(in_ready8), 64'(1));
    check("rst_out_valid", 64'(out_valid8), 64'(0));
    check("rst_product", 64'(product8), 64'(0));
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Max operands: out_valid exactly on the 4th edge after accept, for one cycle.
    send8(8'hFF, 8'hFF, 16'hFE01, 1'b1);
    in_valid8 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("ov_max", 64'(out_valid8), 64'(i == 4));
    end
    drain(8);

    // Back-to-back with in_valid held high.
    send8(8'd7, 8'd9, 16'd63, 1'b1);   t1 = acc_cyc8;
    send8(8'd200, 8'd3, 16'd600, 1'b1); t2 = acc_cyc8;
    send8(8'd0, 8'd255, 16'd0, 1'b1);  t3 = acc_cyc8;
    in_valid8 = 1'b0;
    check("b2b_gap1", 64'(t2 - t1), 64'(5));
    check("b2b_gap2", 64'(t3 - t2), 64'(5));
    drain(8);

    // Backpressure: result held for 10 cycles.
    out_ready8 = 1'b0;
    send8(8'd13, 8'd11, 16'd143, 1'b1);
    in_valid8 = 1'b0;
    k = 0;
    while (!out_valid8 && k < 20) begin @(negedge clk); k++; end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", 64'(out_valid8), 64'(1));
      check("bp_product", 64'(product8), 64'(143));
      check("bp_in_ready", 64'(in_ready8), 64'(0));
    end
    @(posedge clk); #1 out_ready8 = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_ready", 64'(in_ready8), 64'(1));
    check("bp_idle_valid", 64'(out_valid8), 64'(0));
    check("bp_hold_idle", 64'(product8), 64'(143));

    // Reset in the second CALC cycle discards the operation.
    send8(8'd100, 8'd100, 16'd0, 1'b0);
    in_valid8 = 1'b0;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid8), 64'(0));
    check("mid_rst_ready", 64'(in_ready8), 64'(1));
    check("mid_rst_product", 64'(product8), 64'(0));
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    send8(8'd2, 8'd3, 16'd6, 1'b1);
    in_valid8 = 1'b0;
    drain(8);

`ifdef RADIX4_SEQ_MULT_SIGNED_EN
    sgn8 = 1'b1;
    send8(8'h80, 8'h80, 16'h4000, 1'b1);
    send8(8'hFF, 8'h01, 16'hFFFF, 1'b1);
    send8(8'h7F, 8'h80, 16'hC080, 1'b1);
    in_valid8 = 1'b0;
    drain(8);
    sgn8 = 1'b0;
    send8(8'hFF, 8'hFF, 16'hFE01, 1'b1);
    in_valid8 = 1'b0;
    drain(8);
`endif

    // WIDTH=16: corner pairs then random pairs, streamed back-to-back.
    begin
      logic [15:0] corners [3];
      corners[0] = 16'h0000; corners[1] = 16'h0001; corners[2] = 16'hFFFF;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          send16(corners[i], corners[j]);
    end
    for (int n = 0; n < 1500; n++)
      send16(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
    in_valid16 = 1'b0;
    drain(16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
